// File: rtl/axis_mash.sv
// axis_mash: MASH sigma-delta modulator, ORDER cascaded stages, AXI-Stream in/out.
// Optional dither LFSR on stage-1 carry-in, enabled by macro AXIS_MASH_DITHER_EN.
module axis_mash #(
  parameter  int WIDTH = 16,
  parameter  int ORDER = 2,
  localparam int OUT_W = ORDER + 1
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic [WIDTH-1:0]        s_axis_data_tdata,
  input  logic                    s_axis_data_tvalid,
  output logic                    s_axis_data_tready,
  output logic signed [OUT_W-1:0] m_axis_data_tdata,
  output logic [WIDTH-1:0]        m_axis_data_terror,
  output logic                    m_axis_data_tvalid,
  input  logic                    m_axis_data_tready
);

  logic             en;
  logic             d;
  logic [WIDTH-1:0] e_q [ORDER];
  logic [WIDTH-1:0] e_d [ORDER];
  logic [ORDER-1:0] c_d;
  logic signed [OUT_W-1:0] y_d;

  assign s_axis_data_tready = !m_axis_data_tvalid || m_axis_data_tready;
  assign en = s_axis_data_tvalid && s_axis_data_tready;

`ifdef AXIS_MASH_DITHER_EN
  logic [31:0] lfsr_q;
  assign d = lfsr_q[0];

  // Galois LFSR x^32+x^22+x^2+x+1, one step per accepted sample
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      lfsr_q <= 32'h0000_0001;
    end else if (en) begin
      lfsr_q <= {1'b0, lfsr_q[31:1]} ^
                (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    end
  end
`else
  assign d = 1'b0;
`endif

  // Cascade of accumulators, each fed by the new residue of the one before
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] prev;
    e_d  = '{default: '0};
    c_d  = '0;
    sum  = {1'b0, e_q[0]} + {1'b0, s_axis_data_tdata} +
           {{WIDTH{1'b0}}, d};
    c_d[0] = sum[WIDTH];
    e_d[0] = sum[WIDTH-1:0];
    prev   = sum[WIDTH-1:0];
    for (int i = 1; i < ORDER; i++) begin
      sum    = {1'b0, e_q[i]} + {1'b0, prev};
      c_d[i] = sum[WIDTH];
      e_d[i] = sum[WIDTH-1:0];
      prev   = sum[WIDTH-1:0];
    end
  end

  // Residue registers advance only on an accepted sample
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ORDER; i++) e_q[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < ORDER; i++) e_q[i] <= e_d[i];
    end
  end

  generate
    if (ORDER < 1 || ORDER > 3) begin : g_bad
      $error("axis_mash: ORDER must be in 1..3");
    end
    if (ORDER == 1) begin : g_o1
      assign y_d = {1'b0, c_d[0]};
    end else if (ORDER == 2) begin : g_o2
      logic c2_p;
      // Previous stage-2 carry for the first difference
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) c2_p <= 1'b0;
        else if (en) c2_p <= c_d[1];
      end
      assign y_d = $signed({2'b0, c_d[0]}) +
                   $signed({2'b0, c_d[1]}) -
                   $signed({2'b0, c2_p});
    end else begin : g_o3
      logic c2_p;
      logic c3_p;
      logic c3_pp;
      // Carry history for first and second differences
      always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
          c2_p  <= 1'b0;
          c3_p  <= 1'b0;
          c3_pp <= 1'b0;
        end else if (en) begin
          c2_p  <= c_d[1];
          c3_p  <= c_d[2];
          c3_pp <= c3_p;
        end
      end
      assign y_d = $signed({3'b0, c_d[0]}) +
                   $signed({3'b0, c_d[1]}) -
                   $signed({3'b0, c2_p}) +
                   $signed({3'b0, c_d[2]}) -
                   $signed({2'b0, c3_p, 1'b0}) +
                   $signed({3'b0, c3_pp});
    end
  endgenerate

  // Output register: load on accept, drop valid when drained without refill
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      m_axis_data_tdata  <= '0;
      m_axis_data_terror <= '0;
      m_axis_data_tvalid <= 1'b0;
    end else if (en) begin
      m_axis_data_tdata  <= y_d;
      m_axis_data_terror <= e_d[ORDER-1];
      m_axis_data_tvalid <= 1'b1;
    end else if (m_axis_data_tready) begin
      m_axis_data_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_mash.sv
// tb_axis_mash: three axis_mash instances (ORDER 1,2,3) sharing handshakes,
// checked against a spec-level arithmetic model plus fixed vector tables.
module tb_axis_mash;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic [15:0] x1, x2, x3;
  logic        s_valid, m_ready;
  logic        r1, r2, r3;
  logic        v1, v2, v3;
  logic signed [1:0] y1;
  logic signed [2:0] y2;
  logic signed [3:0] y3;
  logic [15:0] t1, t2, t3;

  axis_mash #(.WIDTH(16), .ORDER(1)) u_o1 (
    .aclk(clk), .arst_n(arst_n),
    .s_axis_data_tdata(x1), .s_axis_data_tvalid(s_valid),
    .s_axis_data_tready(r1),
    .m_axis_data_tdata(y1), .m_axis_data_terror(t1),
    .m_axis_data_tvalid(v1), .m_axis_data_tready(m_ready)
  );

  axis_mash #(.WIDTH(16), .ORDER(2)) u_o2 (
    .aclk(clk), .arst_n(arst_n),
    .s_axis_data_tdata(x2), .s_axis_data_tvalid(s_valid),
    .s_axis_data_tready(r2),
    .m_axis_data_tdata(y2), .m_axis_data_terror(t2),
    .m_axis_data_tvalid(v2), .m_axis_data_tready(m_ready)
  );

  axis_mash #(.WIDTH(16), .ORDER(3)) u_o3 (
    .aclk(clk), .arst_n(arst_n),
    .s_axis_data_tdata(x3), .s_axis_data_tvalid(s_valid),
    .s_axis_data_tready(r3),
    .m_axis_data_tdata(y3), .m_axis_data_terror(t3),
    .m_axis_data_tvalid(v3), .m_axis_data_tready(m_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input integer act, input integer exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-order accumulators as integers modulo 2^16
  int          me [4][3];
  int          h2p [4];
  int          h3p [4];
  int          h3pp [4];
  int          ey [4];
  int          ee [4];
  bit          ev;
  logic [31:0] lfsr;

  function automatic void model_reset();
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 3; i++) me[o][i] = 0;
      h2p[o] = 0; h3p[o] = 0; h3pp[o] = 0;
      ey[o] = 0; ee[o] = 0;
    end
    ev   = 1'b0;
    lfsr = 32'h1;
  endfunction

  function automatic void model_accept();
    int d;
    d = 0;
`ifdef AXIS_MASH_DITHER_EN
    d = int'(lfsr[0]);
`endif
    for (int o = 1; o <= 3; o++) begin
      int s, t;
      int c [3];
      s = (o == 1 ? int'(x1) : o == 2 ? int'(x2) : int'(x3)) + d;
      c = '{0, 0, 0};
      for (int i = 0; i < o; i++) begin
        t = me[o][i] + s;
        c[i] = t / 65536;
        me[o][i] = t % 65536;
        s = me[o][i];
      end
      ee[o] = me[o][o-1];
      ey[o] = c[0];
      if (o >= 2) ey[o] += c[1] - h2p[o];
      if (o >= 3) ey[o] += c[2] - 2 * h3p[o] + h3pp[o];
      h2p[o]  = c[1];
      h3pp[o] = h3p[o];
      h3p[o]  = c[2];
    end
`ifdef AXIS_MASH_DITHER_EN
    lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
`endif
  endfunction

  // One clock: check ready, clock in, advance model, check outputs
  task automatic step();
    bit rdy_m, en_m;
    #1;
    rdy_m = !ev || m_ready;
    chk("s_tready_o1", r1, rdy_m);
    chk("s_tready_o2", r2, rdy_m);
    chk("s_tready_o3", r3, rdy_m);
    en_m = s_valid && rdy_m;
    @(posedge clk);
    #1;
    if (en_m) begin
      model_accept();
      ev = 1'b1;
    end else if (m_ready) begin
      ev = 1'b0;
    end
    chk("tvalid_o1", v1, ev);
    chk("tvalid_o2", v2, ev);
    chk("tvalid_o3", v3, ev);
    chk("tdata_o1", y1, ey[1]);
    chk("tdata_o2", y2, ey[2]);
    chk("tdata_o3", y3, ey[3]);
    chk("terror_o1", t1, ee[1]);
    chk("terror_o2", t2, ee[2]);
    chk("terror_o3", t3, ee[3]);
  endtask

  typedef struct {
    logic [15:0] x1, x2, x3;
    int y1, e1, y2, e2, y3, e3;
  } vec_t;

  vec_t tbl [6];
  int   rseq [4];
  int   frozen;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h8000, 16'h0000, 0, 'hFFFF, 0, 'h8000, 0, 0};
    tbl[1] = '{16'hFFFF, 16'h8000, 16'h0000, 1, 'hFFFE, 1, 'h8000, 0, 0};
    tbl[2] = '{16'hFFFF, 16'h8000, 16'h0000, 1, 'hFFFD, 1, 'h0000, 0, 0};
    tbl[3] = '{16'hFFFF, 16'h8000, 16'h0000, 1, 'hFFFC, 0, 'h0000, 0, 0};
    tbl[4] = '{16'hFFFF, 16'h8000, 16'h0000, 1, 'hFFFB, 0, 'h8000, 0, 0};
    tbl[5] = '{16'hFFFF, 16'h8000, 16'h0000, 1, 'hFFFA, 1, 'h8000, 0, 0};
    rseq = '{0, 1, 1, 0};

    arst_n  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    x1 = '0; x2 = '0; x3 = '0;
    model_reset();
    #12;
    chk("rst_tvalid_o2", v2, 0);
    chk("rst_tdata_o2", y2, 0);
    chk("rst_terror_o2", t2, 0);
    chk("rst_tvalid_o3", v3, 0);
    arst_n = 1'b1;

    // Fixed vectors from a clean start
    for (int k = 0; k < 6; k++) begin
      x1 = tbl[k].x1; x2 = tbl[k].x2; x3 = tbl[k].x3;
      s_valid = 1'b1;
      m_ready = 1'b1;
      step();
`ifndef AXIS_MASH_DITHER_EN
      chk("tbl_y1", y1, tbl[k].y1);
      chk("tbl_e1", t1, tbl[k].e1);
      chk("tbl_y2", y2, tbl[k].y2);
      chk("tbl_e2", t2, tbl[k].e2);
      chk("tbl_y3", y3, tbl[k].y3);
      chk("tbl_e3", t3, tbl[k].e3);
`endif
    end

    // Output backpressure for 5 cycles mid-stream
    for (int k = 0; k < 3; k++) step();
    m_ready = 1'b0;
    frozen  = int'(y2);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_frozen_o2", y2, frozen);
      chk("bp_s_tready_o2", r2, 0);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();

    // Asynchronous reset between edges
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_tvalid_o1", v1, 0);
    chk("arst_tvalid_o2", v2, 0);
    chk("arst_tdata_o2", y2, 0);
    model_reset();
    @(posedge clk);
    #2;
    arst_n = 1'b1;
    x1 = 16'hFFFF; x2 = 16'h8000; x3 = 16'h0000;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
`ifndef AXIS_MASH_DITHER_EN
      chk("arst_seq_o2", y2, rseq[k]);
`endif
    end

    // ORDER 3 with zero input stays at zero
    for (int k = 0; k < 100; k++) begin
      x1 = 16'($urandom);
      x2 = 16'($urandom);
      x3 = 16'h0000;
      step();
`ifndef AXIS_MASH_DITHER_EN
      chk("zero_y_o3", y3, 0);
      chk("zero_e_o3", t3, 0);
`endif
    end

    // Random data and random handshakes
    for (int k = 0; k < 3000; k++) begin
      x1 = 16'($urandom);
      x2 = 16'($urandom);
      x3 = 16'($urandom);
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef AXIS_MASH_DITHER_EN
    // Dither only, from reset
    arst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    arst_n = 1'b1;
    x1 = '0; x2 = '0; x3 = '0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 4096; k++) step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
